// File: rtl/tetris_pkg.sv
// Shared widths, FSM state type and piece-type codes for the piece-control blocks.
package tetris_pkg;

  localparam int BOARD_W = 32;
  localparam int LOC_W   = 5;
  localparam int ROT_W   = 2;
  localparam int TYPE_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } mr_state_t;

  localparam logic [TYPE_W-1:0] PIECE_I = 2'd0;
  localparam logic [TYPE_W-1:0] PIECE_O = 2'd1;
  localparam logic [TYPE_W-1:0] PIECE_T = 2'd2;
  localparam logic [TYPE_W-1:0] PIECE_L = 2'd3;

endpackage

// File: rtl/button_debounce.sv
// Synchronizes one raw button and filters it into a debounced level plus a
// rising-edge strobe that coincides with the level going high.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clka,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync1;
  logic       sync2;
  logic [7:0] cnt;
  logic       flip;

  // The strobe is taken from the flip condition so the pending flag sets on the
  // same edge that the debounced level changes.
  assign flip = (sync2 != level) && (cnt == LAST);
  assign rise = flip && sync2;

  always_ff @(posedge clka or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (flip) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/move_request_ctrl.sv
// Initiator side of the move_piece start/done handshake: queues debounced
// button requests, issues one command at a time and owns the piece state.
module move_request_ctrl
  import tetris_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic               clka,
  input  logic               reset,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_rotate,
  input  logic               spawn,
  input  logic [BOARD_W-1:0] spawn_board,
  input  logic [TYPE_W-1:0]  spawn_type,
  input  logic [LOC_W-1:0]   spawn_location,
  output logic               mp_start,
  output logic               mp_left,
  output logic               mp_right,
  output logic               mp_rotate,
  output logic [BOARD_W-1:0] mp_board,
  output logic [TYPE_W-1:0]  mp_type,
  output logic [LOC_W-1:0]   mp_location,
  output logic [ROT_W-1:0]   mp_rotation,
  input  logic               mp_done,
  input  logic [BOARD_W-1:0] mp_new_board,
  input  logic [LOC_W-1:0]   mp_new_location,
  input  logic [ROT_W-1:0]   mp_new_rotation,
  output logic               busy,
  output logic               spawn_dropped,
  output logic               timeout_err
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  // Bit order for pend/cmd/rise: [0] left, [1] right, [2] rotate.
  logic [2:0]         rise;
  logic [2:0]         unused_levels;

  mr_state_t          state, state_next;
  logic [2:0]         pend, pend_next;
  logic [2:0]         cmd, cmd_next;
  logic [BOARD_W-1:0] board, board_next;
  logic [TYPE_W-1:0]  ptype, ptype_next;
  logic [LOC_W-1:0]   loc, loc_next;
  logic [ROT_W-1:0]   rot, rot_next;
  logic [7:0]         tcnt, tcnt_next;
  logic               dropped_next;
  logic               tout_next;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clka(clka), .reset(reset), .raw(btn_left), .level(unused_levels[0]), .rise(rise[0])
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clka(clka), .reset(reset), .raw(btn_right), .level(unused_levels[1]), .rise(rise[1])
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rotate (
    .clka(clka), .reset(reset), .raw(btn_rotate), .level(unused_levels[2]), .rise(rise[2])
  );

  always_ff @(posedge clka or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      pend          <= '0;
      cmd           <= '0;
      board         <= '0;
      ptype         <= '0;
      loc           <= '0;
      rot           <= '0;
      tcnt          <= '0;
      spawn_dropped <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= state_next;
      pend          <= pend_next;
      cmd           <= cmd_next;
      board         <= board_next;
      ptype         <= ptype_next;
      loc           <= loc_next;
      rot           <= rot_next;
      tcnt          <= tcnt_next;
      spawn_dropped <= dropped_next;
      timeout_err   <= tout_next;
    end
  end

  always_comb begin
    state_next   = state;
    pend_next    = pend;
    cmd_next     = cmd;
    board_next   = board;
    ptype_next   = ptype;
    loc_next     = loc;
    rot_next     = rot;
    tcnt_next    = tcnt;
    tout_next    = 1'b0;
    dropped_next = spawn && (state != ST_IDLE);

    unique case (state)
      ST_IDLE: begin
        if (spawn) begin
          board_next = spawn_board;
          ptype_next = spawn_type;
          loc_next   = spawn_location;
          rot_next   = '0;
          pend_next  = '0;
        end else if (pend[2]) begin
          cmd_next     = 3'b100;
          pend_next[2] = 1'b0;
          state_next   = ST_ISSUE;
        end else if (pend[0] && pend[1]) begin
          // Opposing moves cancel each other rather than picking a winner.
          pend_next[1:0] = 2'b00;
        end else if (pend[0]) begin
          cmd_next     = 3'b001;
          pend_next[0] = 1'b0;
          state_next   = ST_ISSUE;
        end else if (pend[1]) begin
          cmd_next     = 3'b010;
          pend_next[1] = 1'b0;
          state_next   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tcnt_next  = '0;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (mp_done) begin
          board_next = mp_new_board;
          loc_next   = mp_new_location;
          rot_next   = mp_new_rotation;
          cmd_next   = '0;
          state_next = ST_IDLE;
        end else if (tcnt == TMO_LAST) begin
          tout_next  = 1'b1;
          cmd_next   = '0;
          state_next = ST_IDLE;
        end else begin
          tcnt_next = tcnt + 8'd1;
        end
      end
      default: begin
        cmd_next   = '0;
        state_next = ST_IDLE;
      end
    endcase

    // New presses are always captured, even on a cycle that clears flags.
    pend_next = pend_next | rise;
  end

  assign mp_start    = (state == ST_ISSUE);
  assign busy        = (state != ST_IDLE);
  assign mp_left     = cmd[0];
  assign mp_right    = cmd[1];
  assign mp_rotate   = cmd[2];
  assign mp_board    = board;
  assign mp_type     = ptype;
  assign mp_location = loc;
  assign mp_rotation = rot;

endmodule

// File: tb/tb_move_request_ctrl.sv
// Directed and randomized checks of move_request_ctrl against a cycle-level
// behavioural model of the button queue and handshake rules.
module tb_move_request_ctrl;

  localparam int DEB = 4;
  localparam int TMO = 255;

  logic        clka = 1'b0;
  logic        reset = 1'b1;
  logic        btn_left = 1'b0, btn_right = 1'b0, btn_rotate = 1'b0;
  logic        spawn = 1'b0;
  logic [31:0] spawn_board = '0;
  logic [1:0]  spawn_type = '0;
  logic [4:0]  spawn_location = '0;
  logic        mp_start, mp_left, mp_right, mp_rotate;
  logic [31:0] mp_board;
  logic [1:0]  mp_type;
  logic [4:0]  mp_location;
  logic [1:0]  mp_rotation;
  logic        mp_done = 1'b0;
  logic [31:0] mp_new_board = '0;
  logic [4:0]  mp_new_location = '0;
  logic [1:0]  mp_new_rotation = '0;
  logic        busy, spawn_dropped, timeout_err;

  move_request_ctrl #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
    .clka(clka), .reset(reset),
    .btn_left(btn_left), .btn_right(btn_right), .btn_rotate(btn_rotate),
    .spawn(spawn), .spawn_board(spawn_board), .spawn_type(spawn_type),
    .spawn_location(spawn_location),
    .mp_start(mp_start), .mp_left(mp_left), .mp_right(mp_right), .mp_rotate(mp_rotate),
    .mp_board(mp_board), .mp_type(mp_type), .mp_location(mp_location),
    .mp_rotation(mp_rotation), .mp_done(mp_done), .mp_new_board(mp_new_board),
    .mp_new_location(mp_new_location), .mp_new_rotation(mp_new_rotation),
    .busy(busy), .spawn_dropped(spawn_dropped), .timeout_err(timeout_err)
  );

  always #5 clka = ~clka;

  // Reference model: phase 0 idle, 1 issuing, 2 waiting for done.
  int          m_phase;
  bit [2:0]    m_pend, m_cmd, m_lvl;
  bit [63:0]   m_hist [3];
  logic [31:0] m_board;
  logic [1:0]  m_type, m_rot;
  logic [4:0]  m_loc;
  int          m_waited;
  bit          m_drop, m_tout;

  int errors = 0, checks = 0;
  bit auto_resp = 1'b0, resp_fixed = 1'b0, noise_done = 1'b0;
  int resp_lat = 1;
  logic [31:0] fx_board = '0;
  logic [4:0]  fx_loc = '0;
  logic [1:0]  fx_rot = '0;
  int starts = 0, drops = 0, touts = 0, busy_cycles = 0, cyc = 0;
  int last_start = -1, last_commit = -1;
  logic [2:0] st_cmd = '0;
  logic [4:0] st_loc = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_pend = '0; m_cmd = '0; m_lvl = '0;
    for (int b = 0; b < 3; b++) m_hist[b] = '0;
    m_board = '0; m_type = '0; m_rot = '0; m_loc = '0;
    m_waited = 0; m_drop = 1'b0; m_tout = 1'b0;
  endtask

  // One rising edge: the debounced level follows the synced button (raw delayed
  // two edges) once the last DEB synced samples all disagree with it.
  task automatic model_edge();
    bit [2:0] raw, rise;
    bit all;
    raw = {btn_rotate, btn_right, btn_left};
    rise = '0;
    if (reset) begin
      model_reset();
      return;
    end
    for (int b = 0; b < 3; b++) begin
      all = 1'b1;
      for (int i = 1; i <= DEB; i++) if (m_hist[b][i] == m_lvl[b]) all = 1'b0;
      rise[b] = all && !m_lvl[b];
      if (all) m_lvl[b] = !m_lvl[b];
      m_hist[b] = {m_hist[b][62:0], raw[b]};
    end
    m_drop = spawn && (m_phase != 0);
    m_tout = 1'b0;
    case (m_phase)
      0: begin
        if (spawn) begin
          m_board = spawn_board; m_type = spawn_type; m_loc = spawn_location; m_rot = '0;
          m_pend = '0;
        end else if (m_pend[2]) begin
          m_cmd = 3'b100; m_pend[2] = 1'b0; m_phase = 1;
        end else if (m_pend[0] && m_pend[1]) begin
          m_pend[1:0] = 2'b00;
        end else if (m_pend[0]) begin
          m_cmd = 3'b001; m_pend[0] = 1'b0; m_phase = 1;
        end else if (m_pend[1]) begin
          m_cmd = 3'b010; m_pend[1] = 1'b0; m_phase = 1;
        end
      end
      1: begin
        m_phase = 2; m_waited = 0;
      end
      default: begin
        if (mp_done) begin
          m_board = mp_new_board; m_loc = mp_new_location; m_rot = mp_new_rotation;
          m_cmd = '0; m_phase = 0; last_commit = cyc;
        end else begin
          m_waited++;
          if (m_waited == TMO) begin
            m_tout = 1'b1; m_cmd = '0; m_phase = 0;
          end
        end
      end
    endcase
    m_pend = m_pend | rise;
  endtask

  task automatic check_output();
    chk("mp_start", 32'(mp_start), 32'(m_phase == 1));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("cmd", 32'({mp_rotate, mp_right, mp_left}), 32'(m_cmd));
    chk("board", mp_board, m_board);
    chk("type", 32'(mp_type), 32'(m_type));
    chk("location", 32'(mp_location), 32'(m_loc));
    chk("rotation", 32'(mp_rotation), 32'(m_rot));
    chk("spawn_dropped", 32'(spawn_dropped), 32'(m_drop));
    chk("timeout_err", 32'(timeout_err), 32'(m_tout));
  endtask

  task automatic step();
    if (auto_resp && m_phase == 2 && m_waited == resp_lat) begin
      mp_done = 1'b1;
      if (resp_fixed) begin
        mp_new_board = fx_board; mp_new_location = fx_loc; mp_new_rotation = fx_rot;
      end else begin
        mp_new_board = $urandom; mp_new_location = 5'($urandom); mp_new_rotation = 2'($urandom);
      end
    end else begin
      mp_done = noise_done;
    end
    @(posedge clka);
    cyc++;
    model_edge();
    #1;
    if (mp_start) begin
      starts++; last_start = cyc;
      st_cmd = {mp_rotate, mp_right, mp_left}; st_loc = mp_location;
    end
    busy_cycles += int'(busy);
    drops += int'(spawn_dropped);
    touts += int'(timeout_err);
    check_output();
  endtask

  task automatic press(input logic [2:0] b, input int n);
    {btn_rotate, btn_right, btn_left} = b;
    repeat (n) step();
    {btn_rotate, btn_right, btn_left} = 3'b000;
  endtask

  task automatic do_spawn(input logic [31:0] bd, input logic [1:0] ty, input logic [4:0] lc);
    spawn = 1'b1; spawn_board = bd; spawn_type = ty; spawn_location = lc;
    step();
    spawn = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst_board", mp_board, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    repeat (2) step();
    reset = 1'b0;

    // Reset in the middle of a transaction, then a stray done must not commit.
    press(3'b001, 8);
    chk("rmw_in_wait", 32'(busy), 32'h1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("rmw_busy", 32'(busy), 32'h0);
    chk("rmw_cmd", 32'({mp_start, mp_rotate, mp_right, mp_left}), 32'h0);
    check_output();
    step();
    reset = 1'b0;
    noise_done = 1'b1;
    mp_new_board = 32'hFFFF_FFFF; mp_new_location = 5'd31; mp_new_rotation = 2'd3;
    step();
    noise_done = 1'b0;
    chk("rmw_no_commit_board", mp_board, 32'h0);
    chk("rmw_no_commit_loc", 32'(mp_location), 32'h0);

    // Spawn then a left move with a fixed response.
    do_spawn(32'hD000_0004, 2'd0, 5'd2);
    auto_resp = 1'b1; resp_fixed = 1'b1; resp_lat = 1;
    fx_board = 32'hD000_0002; fx_loc = 5'd1; fx_rot = 2'd0;
    starts = 0;
    press(3'b001, 8);
    repeat (10) step();
    chk("sl_starts", 32'(starts), 32'd1);
    chk("sl_cmd", 32'(st_cmd), 32'b001);
    chk("sl_issue_loc", 32'(st_loc), 32'd2);
    chk("sl_loc", 32'(mp_location), 32'd1);
    chk("sl_board", mp_board, 32'hD000_0002);
    resp_fixed = 1'b0;

    // A 3-cycle glitch is shorter than the debounce window.
    starts = 0;
    press(3'b100, 3);
    repeat (12) step();
    chk("glitch_starts", 32'(starts), 32'd0);

    // Left+right cancel; with rotate, only rotate runs.
    starts = 0;
    press(3'b011, 8);
    repeat (8) step();
    chk("lr_cancel_starts", 32'(starts), 32'd0);
    press(3'b111, 8);
    repeat (16) step();
    chk("lrr_starts", 32'(starts), 32'd1);
    chk("lrr_cmd", 32'(st_cmd), 32'b100);

    // Timeout: rotate with no response.
    do_spawn(32'h1234_5678, 2'd2, 5'd6);
    auto_resp = 1'b0; touts = 0; busy_cycles = 0;
    press(3'b100, 8);
    repeat (270) step();
    chk("tmo_pulses", 32'(touts), 32'd1);
    chk("tmo_busy_cycles", 32'(busy_cycles), 32'(TMO + 1));
    chk("tmo_loc", 32'(mp_location), 32'd6);
    chk("tmo_rot", 32'(mp_rotation), 32'd0);

    // Spawn while busy is dropped; a right press queued during WAIT follows the commit.
    auto_resp = 1'b1; resp_lat = 10; drops = 0;
    press(3'b001, 8);
    do_spawn(32'hAAAA_5555, 2'd3, 5'd17);
    press(3'b010, 8);
    repeat (12) step();
    chk("drop_pulses", 32'(drops), 32'd1);
    chk("queued_right_cmd", 32'(st_cmd), 32'b010);
    chk("queued_right_gap", 32'(last_start - last_commit), 32'd1);

    // Randomized traffic.
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(5) == 0) btn_left = ~btn_left;
      if ($urandom_range(5) == 0) btn_right = ~btn_right;
      if ($urandom_range(5) == 0) btn_rotate = ~btn_rotate;
      spawn = ($urandom_range(24) == 0);
      spawn_board = $urandom; spawn_type = 2'($urandom); spawn_location = 5'($urandom);
      if (m_phase == 1) resp_lat = ($urandom_range(9) == 0) ? 300 : int'($urandom_range(5));
      noise_done = (m_phase == 0) && ($urandom_range(29) == 0);
      mp_new_board = $urandom; mp_new_location = 5'($urandom); mp_new_rotation = 2'($urandom);
      step();
    end
    spawn = 1'b0; noise_done = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
